// File: rtl/fetch_pkg.sv
// fetch_pkg: shared constants, entry layout and helpers for the instruction-fetch front end.
package fetch_pkg;

   // Default widths of the fetch datapath.
   localparam int DEF_XLEN = 32;
   localparam int DEF_AW   = 10;

   // Position of the opcode field inside an instruction word.
   localparam int OP_HI = DEF_XLEN - 1;
   localparam int OP_LO = DEF_XLEN - 6;

   // Opcode that stops further fetching once it has been captured.
   localparam logic [5:0] HLT_OP = 6'h3F;

   // One prefetch FIFO entry: the instruction word and the address it came from.
   typedef struct packed {
      logic [DEF_XLEN-1:0] instr;
      logic [DEF_AW-1:0]   pc;
   } fetch_entry_t;

   // 32-bit add that sticks at all-ones instead of wrapping.
   function automatic logic [31:0] sat_add32(input logic [31:0] a, input logic [31:0] b);
      logic [32:0] sum;
      sum = {1'b0, a} + {1'b0, b};
      return sum[32] ? 32'hFFFF_FFFF : sum[31:0];
   endfunction

endpackage

// File: rtl/fetch_queue_if.sv
// fetch_queue_if: instruction-memory port, branch redirect and decode handshake of the fetch unit.
interface fetch_queue_if #(
   parameter int XLEN = 32,
   parameter int AW   = 10
);
   logic            imem_req;
   logic [AW-1:0]   imem_addr;
   logic [XLEN-1:0] imem_rdata;
   logic            redirect;
   logic [AW-1:0]   redirect_pc;
   logic            instr_valid;
   logic [XLEN-1:0] instr;
   logic [AW-1:0]   instr_pc;
   logic            instr_ready;
   logic            halted;

   // Fetch unit side.
   modport master (
      output imem_req, imem_addr, instr_valid, instr, instr_pc, halted,
      input  imem_rdata, redirect, redirect_pc, instr_ready
   );

   // Memory / pipeline side.
   modport slave (
      input  imem_req, imem_addr, instr_valid, instr, instr_pc, halted,
      output imem_rdata, redirect, redirect_pc, instr_ready
   );
endinterface

// File: rtl/sync_fifo.sv
// sync_fifo: DEPTH-entry FIFO with register-based storage, occupancy count and flush.
// The head is read straight out of the storage registers, never from the write data.
module sync_fifo #(
   parameter int W     = 42,
   parameter int DEPTH = 4,
   parameter int CW    = $clog2(DEPTH) + 1
) (
   input  logic          clk1,
   input  logic          rst_n,
   input  logic          flush,
   input  logic          push,
   input  logic [W-1:0]  wdata,
   input  logic          pop,
   output logic [W-1:0]  head,
   output logic          head_valid,
   output logic [CW-1:0] count
);
   localparam int            PW   = $clog2(DEPTH);
   localparam logic [CW-1:0] FULL = CW'(DEPTH);
   localparam logic [CW-1:0] ONE  = {{(CW-1){1'b0}}, 1'b1};

   logic [W-1:0]  mem_r [DEPTH];
   logic [PW-1:0] wr_ptr_r;
   logic [PW-1:0] rd_ptr_r;
   logic [CW-1:0] count_r;
   logic          pop_ok_s;
   logic          push_ok_s;

   // Qualify push and pop against the current occupancy.
   always_comb begin
      pop_ok_s  = pop && (count_r != {CW{1'b0}});
      push_ok_s = push && ((count_r != FULL) || pop_ok_s);
   end

   // Storage, pointers and count; flush empties the queue in one cycle.
   always_ff @(posedge clk1 or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < DEPTH; i++) begin
            mem_r[i] <= {W{1'b0}};
         end
         wr_ptr_r <= {PW{1'b0}};
         rd_ptr_r <= {PW{1'b0}};
         count_r  <= {CW{1'b0}};
      end else if (flush) begin
         wr_ptr_r <= {PW{1'b0}};
         rd_ptr_r <= {PW{1'b0}};
         count_r  <= {CW{1'b0}};
      end else begin
         if (push_ok_s) begin
            mem_r[wr_ptr_r] <= wdata;
            wr_ptr_r        <= wr_ptr_r + {{(PW-1){1'b0}}, 1'b1};
         end
         if (pop_ok_s) begin
            rd_ptr_r <= rd_ptr_r + {{(PW-1){1'b0}}, 1'b1};
         end
         case ({push_ok_s, pop_ok_s})
            2'b10:   count_r <= count_r + ONE;
            2'b01:   count_r <= count_r - ONE;
            default: count_r <= count_r;
         endcase
      end
   end

   assign head       = mem_r[rd_ptr_r];
   assign head_valid = (count_r != {CW{1'b0}});
   assign count      = count_r;
endmodule

// File: rtl/fetch_queue.sv
// fetch_queue: PC generator, 1-cycle instruction-memory capture and DEPTH-entry prefetch FIFO.
// Optional build macro FETCH_STATS_EN adds stat_fetched / stat_flushed counters.
module fetch_queue #(
   parameter int            XLEN     = 32,
   parameter int            AW       = 10,
   parameter int            DEPTH    = 4,
   parameter logic [5:0]    HLT_OP   = fetch_pkg::HLT_OP,
   parameter logic [AW-1:0] RESET_PC = {AW{1'b0}}
) (
   input logic           clk1,
   input logic           rst_n,
   fetch_queue_if.master bus
`ifdef FETCH_STATS_EN
   ,
   output logic [31:0]   stat_fetched,
   output logic [31:0]   stat_flushed
`endif
);
   import fetch_pkg::*;

   localparam int          OP_W    = OP_HI - OP_LO + 1;
   localparam int          CW      = $clog2(DEPTH) + 1;
   localparam logic [CW:0] DEPTH_V = (CW+1)'(DEPTH);

   logic [AW-1:0]      pc_r;
   logic [AW-1:0]      inflight_pc_r;
   logic               inflight_r;
   logic               halted_r;
   logic [CW:0]        occupancy_s;
   logic               issue_s;
   logic               push_s;
   logic               pop_s;
   logic               hlt_s;
   logic [CW-1:0]      count_s;
   logic               head_valid_s;
   logic [XLEN+AW-1:0] head_s;

   // Issue, capture and pop decisions; redirect suppresses all three.
   always_comb begin
      occupancy_s = {1'b0, count_s} + {{CW{1'b0}}, inflight_r};
      issue_s     = rst_n && !bus.redirect && !halted_r && (occupancy_s < DEPTH_V);
      push_s      = inflight_r && !bus.redirect && !halted_r;
      pop_s       = head_valid_s && bus.instr_ready && !bus.redirect;
      hlt_s       = (bus.imem_rdata[XLEN-1 -: OP_W] == HLT_OP);
   end

   // PC, outstanding-request tracking and halt state.
   always_ff @(posedge clk1 or negedge rst_n) begin
      if (!rst_n) begin
         pc_r          <= RESET_PC;
         inflight_pc_r <= RESET_PC;
         inflight_r    <= 1'b0;
         halted_r      <= 1'b0;
      end else if (bus.redirect) begin
         pc_r       <= bus.redirect_pc;
         inflight_r <= 1'b0;
         halted_r   <= 1'b0;
      end else begin
         inflight_r <= issue_s;
         if (issue_s) begin
            pc_r          <= pc_r + {{(AW-1){1'b0}}, 1'b1};
            inflight_pc_r <= pc_r;
         end
         if (push_s && hlt_s) begin
            halted_r <= 1'b1;
         end
      end
   end

   sync_fifo #(
      .W     (XLEN + AW),
      .DEPTH (DEPTH),
      .CW    (CW)
   ) u_fifo (
      .clk1       (clk1),
      .rst_n      (rst_n),
      .flush      (bus.redirect),
      .push       (push_s),
      .wdata      ({bus.imem_rdata, inflight_pc_r}),
      .pop        (pop_s),
      .head       (head_s),
      .head_valid (head_valid_s),
      .count      (count_s)
   );

   assign bus.imem_req    = issue_s;
   assign bus.imem_addr   = pc_r;
   assign bus.instr_valid = head_valid_s;
   assign bus.instr       = head_s[XLEN+AW-1:AW];
   assign bus.instr_pc    = head_s[AW-1:0];
   assign bus.halted      = halted_r;

`ifdef FETCH_STATS_EN
   logic [31:0] stat_fetched_r;
   logic [31:0] stat_flushed_r;
   logic [31:0] flushed_words_s;

   // Words thrown away by a redirect: queued entries plus the outstanding response.
   always_comb begin
      flushed_words_s = 32'(count_s) + {31'd0, inflight_r};
   end

   // Saturating event counters, updated the cycle after the event.
   always_ff @(posedge clk1 or negedge rst_n) begin
      if (!rst_n) begin
         stat_fetched_r <= 32'd0;
         stat_flushed_r <= 32'd0;
      end else begin
         if (push_s) begin
            stat_fetched_r <= sat_add32(stat_fetched_r, 32'd1);
         end
         if (bus.redirect) begin
            stat_flushed_r <= sat_add32(stat_flushed_r, flushed_words_s);
         end
      end
   end

   assign stat_fetched = stat_fetched_r;
   assign stat_flushed = stat_flushed_r;
`endif
endmodule

// File: tb/tb_fetch_queue.sv
// tb_fetch_queue: table-driven, directed and randomized checks of fetch_queue.
module tb_fetch_queue;
   import fetch_pkg::*;

   localparam int XLEN  = 32;
   localparam int AW    = 10;
   localparam int AWS   = 4;
   localparam int DEPTH = 4;

   logic clk1  = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk1 = ~clk1;

   fetch_queue_if #(.XLEN(XLEN), .AW(AW))  bus ();
   fetch_queue_if #(.XLEN(XLEN), .AW(AWS)) bus_w ();

`ifdef FETCH_STATS_EN
   logic [31:0] st_fet, st_flu, st_fet_w, st_flu_w;
`endif

   fetch_queue #(.XLEN(XLEN), .AW(AW), .DEPTH(DEPTH)) dut (
      .clk1 (clk1), .rst_n (rst_n), .bus (bus)
`ifdef FETCH_STATS_EN
      , .stat_fetched (st_fet), .stat_flushed (st_flu)
`endif
   );

   fetch_queue #(.XLEN(XLEN), .AW(AWS), .DEPTH(DEPTH)) dut_w (
      .clk1 (clk1), .rst_n (rst_n), .bus (bus_w)
`ifdef FETCH_STATS_EN
      , .stat_fetched (st_fet_w), .stat_flushed (st_flu_w)
`endif
   );

   int errors = 0;
   int checks = 0;
   int hlt_addr = -1;

   // Instruction memory contents: opcode never 6'h3F except the chosen HLT address.
   function automatic logic [31:0] mem_word(input int a, input bit use_hlt);
      logic [31:0] w;
      if (use_hlt && a == hlt_addr) begin
         w = 32'hFC00_0000;
      end else begin
         w = (32'(a) * 32'h0001_0DCD) ^ 32'h5A5A_1234;
         w[31:26] = 6'(a % 63);
      end
      return w;
   endfunction

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   task automatic cyc();
      @(posedge clk1);
      #1;
   endtask

   task automatic mid();
      @(negedge clk1);
   endtask

   // Memory with exactly one cycle of read latency; garbage when no request.
   always @(posedge clk1) begin
      bus.imem_rdata   <= bus.imem_req   ? mem_word(int'(bus.imem_addr), 1'b1)   : $urandom();
      bus_w.imem_rdata <= bus_w.imem_req ? mem_word(int'(bus_w.imem_addr), 1'b0) : $urandom();
   end

   // Reference model for the random phase: in-order delivery from the last redirect target,
   // nothing delivered after a HLT until the next redirect.
   bit           mon_en = 1'b0;
   int           mexp   = 0;
   bit           mhlt   = 1'b0;
   int           mdeliv = 0;
   always @(negedge clk1) begin
      logic [31:0]  w;
      fetch_entry_t head_e;
      if (mon_en) begin
         head_e = '{instr: bus.instr, pc: bus.instr_pc};
         if (bus.redirect) begin
            chk("rnd_redirect_req", bus.imem_req, 0);
            mexp = int'(bus.redirect_pc);
            mhlt = 1'b0;
         end else begin
            if (bus.halted) chk("rnd_halted_req", bus.imem_req, 0);
            if (mhlt) begin
               chk("rnd_after_hlt_valid", bus.instr_valid, 0);
            end else if (bus.instr_valid && bus.instr_ready) begin
               w = mem_word(mexp, 1'b1);
               chk("rnd_pc", head_e.pc, mexp);
               chk("rnd_instr", head_e.instr, w);
               if (w[31:26] == 6'h3F) mhlt = 1'b1;
               mexp = (mexp + 1) % 1024;
               mdeliv++;
            end
         end
      end
   end

   typedef struct {
      logic req;
      int   addr;
      logic valid;
      int   pc;
   } vec_t;
   vec_t tbl [10];

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      int  exp_pc;
      bit  done;
      int  wexp;
      int  wn;

      // Startup vectors: request every cycle, first delivery two cycles after release.
      for (int k = 0; k < 10; k++) begin
         tbl[k].req   = 1'b1;
         tbl[k].addr  = k;
         tbl[k].valid = (k >= 2);
         tbl[k].pc    = (k >= 2) ? k - 2 : 0;
      end

      bus.redirect = 1'b0;   bus.redirect_pc = 10'd0;  bus.instr_ready = 1'b0;
      bus_w.redirect = 1'b0; bus_w.redirect_pc = 4'd0; bus_w.instr_ready = 1'b0;

      // Reset state.
      repeat (3) cyc();
      mid();
      chk("rst_req", bus.imem_req, 0);
      chk("rst_addr", bus.imem_addr, 0);
      chk("rst_valid", bus.instr_valid, 0);
      chk("rst_instr", bus.instr, 0);
      chk("rst_pc", bus.instr_pc, 0);
      chk("rst_halted", bus.halted, 0);

      // Straight-line fetch from reset release.
      bus.instr_ready = 1'b1;
      for (int k = 0; k < 10; k++) begin
         cyc();
         if (k == 0) rst_n = 1'b1;
         mid();
         chk("line_req", bus.imem_req, tbl[k].req);
         chk("line_addr", bus.imem_addr, tbl[k].addr);
         chk("line_valid", bus.instr_valid, tbl[k].valid);
         if (tbl[k].valid) begin
            chk("line_pc", bus.instr_pc, tbl[k].pc);
            chk("line_instr", bus.instr, mem_word(tbl[k].pc, 1'b1));
         end
      end

      // Backpressure: FIFO fills, requests stop, head holds.
      for (int b = 0; b < 10; b++) begin
         cyc();
         bus.instr_ready = 1'b0;
         mid();
         if (b >= 3) chk("bp_req", bus.imem_req, 0);
         chk("bp_valid", bus.instr_valid, 1);
         chk("bp_pc", bus.instr_pc, 8);
      end
      for (int r = 0; r < 8; r++) begin
         cyc();
         bus.instr_ready = 1'b1;
         mid();
         chk("bp_rel_valid", bus.instr_valid, 1);
         chk("bp_rel_pc", bus.instr_pc, 8 + r);
         chk("bp_rel_instr", bus.instr, mem_word(8 + r, 1'b1));
      end

      // Build 3 queued entries plus one inflight, then redirect to 0x40.
      cyc();
      bus.instr_ready = 1'b0; bus.redirect = 1'b1; bus.redirect_pc = 10'h020;
      mid();
      chk("redir_prep_req", bus.imem_req, 0);
      for (int i = 0; i < 4; i++) begin
         cyc();
         bus.redirect = 1'b0;
         mid();
      end
      cyc();
      bus.redirect = 1'b1; bus.redirect_pc = 10'h040;
      mid();
      chk("redir_req", bus.imem_req, 0);
      chk("redir_head_valid", bus.instr_valid, 1);
      chk("redir_head_pc", bus.instr_pc, 10'h020);
      cyc();
      bus.redirect = 1'b0; bus.instr_ready = 1'b1;
      mid();
      chk("redir_next_valid", bus.instr_valid, 0);
      chk("redir_next_req", bus.imem_req, 1);
      chk("redir_next_addr", bus.imem_addr, 10'h040);
      cyc();
      mid();
      chk("redir_gap_valid", bus.instr_valid, 0);
      for (int i = 0; i < 3; i++) begin
         cyc();
         mid();
         chk("redir_deliv_valid", bus.instr_valid, 1);
         chk("redir_deliv_pc", bus.instr_pc, 10'h040 + i);
         chk("redir_deliv_instr", bus.instr, mem_word(10'h040 + i, 1'b1));
      end

      // HLT at address 7.
      hlt_addr = 7;
      cyc();
      bus.redirect = 1'b1; bus.redirect_pc = 10'd0;
      mid();
      exp_pc = 0;
      done   = 1'b0;
      for (int i = 0; i < 30 && !done; i++) begin
         cyc();
         bus.redirect = 1'b0;
         mid();
         if (bus.instr_valid) begin
            chk("hlt_seq_pc", bus.instr_pc, exp_pc);
            chk("hlt_seq_instr", bus.instr, mem_word(exp_pc, 1'b1));
            if (exp_pc == 7) done = 1'b1;
            exp_pc++;
         end
      end
      chk("hlt_reached", done, 1);
      for (int i = 0; i < 20; i++) begin
         cyc();
         mid();
         chk("hlt_valid", bus.instr_valid, 0);
         chk("hlt_req", bus.imem_req, 0);
         chk("hlt_halted", bus.halted, 1);
      end

      // Redirect clears halt.
      cyc();
      bus.redirect = 1'b1; bus.redirect_pc = 10'h010;
      mid();
      chk("unhalt_redir_req", bus.imem_req, 0);
      chk("unhalt_redir_halted", bus.halted, 1);
      cyc();
      bus.redirect = 1'b0;
      mid();
      chk("unhalt_halted", bus.halted, 0);
      chk("unhalt_req", bus.imem_req, 1);
      chk("unhalt_addr", bus.imem_addr, 10'h010);
      cyc();
      mid();
      cyc();
      mid();
      chk("unhalt_valid", bus.instr_valid, 1);
      chk("unhalt_pc", bus.instr_pc, 10'h010);
      cyc();
      mid();
      chk("unhalt_pc2", bus.instr_pc, 10'h011);

      // Randomized traffic against the reference model.
      hlt_addr = 300;
      cyc();
      bus.redirect = 1'b1; bus.redirect_pc = 10'd290; bus.instr_ready = 1'b1;
      mon_en = 1'b1;
      mid();
      for (int i = 0; i < 3000; i++) begin
         cyc();
         bus.instr_ready = ($urandom_range(0, 3) != 0);
         bus.redirect    = ($urandom_range(0, 24) == 0);
         bus.redirect_pc = ($urandom_range(0, 1) != 0) ? AW'(300 - int'($urandom_range(0, 8)))
                                                       : AW'($urandom_range(0, 1023));
         mid();
      end
      cyc();
      bus.redirect = 1'b0;
      mon_en = 1'b0;
      mid();
      chk("rnd_progress", (mdeliv > 300), 1);

      // AW=4 wrap on the small instance while the main one runs into a HLT.
      cyc();
      bus.redirect = 1'b1;   bus.redirect_pc = 10'd296;  bus.instr_ready = 1'b1;
      bus_w.redirect = 1'b1; bus_w.redirect_pc = 4'd14;  bus_w.instr_ready = 1'b1;
      mid();
      wexp = 14;
      wn   = 0;
      for (int i = 0; i < 20; i++) begin
         cyc();
         bus.redirect = 1'b0;
         bus_w.redirect = 1'b0;
         mid();
         if (bus_w.instr_valid && wn < 4) begin
            chk("wrap_pc", bus_w.instr_pc, wexp);
            chk("wrap_instr", bus_w.instr, mem_word(wexp, 1'b0));
            wexp = (wexp + 1) % 16;
            wn++;
         end
      end
      chk("wrap_count", wn, 4);
      chk("pre_rst_halted", bus.halted, 1);
      chk("pre_rst_w_valid", bus_w.instr_valid, 1);

      // Reset mid-stream clears everything at once.
      cyc();
      rst_n = 1'b0;
      #1;
      chk("midrst_valid", bus.instr_valid, 0);
      chk("midrst_halted", bus.halted, 0);
      chk("midrst_w_valid", bus_w.instr_valid, 0);
      chk("midrst_w_req", bus_w.imem_req, 0);
`ifdef FETCH_STATS_EN
      chk("midrst_stat_fetched", st_fet, 0);
      chk("midrst_stat_flushed", st_flu, 0);
`endif
      mid();
      cyc();
      mid();
      for (int k = 0; k < 4; k++) begin
         cyc();
         if (k == 0) rst_n = 1'b1;
         mid();
         if (k == 0) begin
            chk("rel_addr", bus.imem_addr, 0);
            chk("rel_w_addr", bus_w.imem_addr, 0);
`ifdef FETCH_STATS_EN
            chk("rel_stat_fetched", st_fet, 0);
`endif
         end
         if (k < 2) begin
            chk("rel_valid", bus.instr_valid, 0);
            chk("rel_w_valid", bus_w.instr_valid, 0);
         end else if (k == 2) begin
            chk("rel_first_valid", bus.instr_valid, 1);
            chk("rel_first_pc", bus.instr_pc, 0);
            chk("rel_first_instr", bus.instr, mem_word(0, 1'b1));
            chk("rel_w_first_valid", bus_w.instr_valid, 1);
            chk("rel_w_first_pc", bus_w.instr_pc, 0);
         end
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
